regfile_access_ctrl: RTL

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Operand-fetch controller in front of a 2-read/1-write register file with
//   registered reads. A request latches two source register numbers, drives
//   them to the register file, captures the returned data and holds it until
//   the consumer takes it. Write-backs pass straight through to the register
//   file and are forwarded into an in-flight fetch so the operands never go
//   stale. A saturating counter records forwarding events.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      operand-fetch request handshake
//   req_rs, req_rt           source register numbers (operand A / B)
//   op_valid/op_ready        operand handshake towards the consumer
//   op_a, op_b               fetched operands
//   wb_valid/wb_ready        write-back handshake (wb_reg, wb_data)
//   rf_ra, rf_rb             register file read addresses
//   rf_rda, rf_rdb           register file read data (one cycle after address)
//   rf_we, rf_wr, rf_wd      register file write port
//   fwd_count                saturating count of forwarding cycles
//
// Parameters
//   ZERO_R0   1: register 0 always reads as zero and is never forwarded
//   CNT_W     width of fwd_count

module regfile_access_ctrl #(
   parameter bit          ZERO_R0 = 1'b0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_rs,
   input  logic [4:0]       req_rt,

   output logic             op_valid,
   input  logic             op_ready,
   output logic [31:0]      op_a,
   output logic [31:0]      op_b,

   input  logic             wb_valid,
   input  logic [4:0]       wb_reg,
   input  logic [31:0]      wb_data,
   output logic             wb_ready,

   output logic [4:0]       rf_ra,
   output logic [4:0]       rf_rb,
   output logic [4:0]       rf_wr,
   output logic [31:0]      rf_wd,
   output logic             rf_we,
   input  logic [31:0]      rf_rda,
   input  logic [31:0]      rf_rdb,

   output logic [CNT_W-1:0] fwd_count
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_e;

   state_e           state_q;
   logic [AW-1:0]    addr_a_q, addr_b_q;
   logic [DW-1:0]    byp_a_q, byp_b_q;
   logic             byp_a_vld_q, byp_b_vld_q;
   logic             op_valid_q;
   logic [DW-1:0]    op_a_q, op_b_q;
   logic [CNT_W-1:0] fwd_cnt_q;

   logic             wb_fire;
   logic             zero_a, zero_b;
   logic             hit_a, hit_b;
   logic             fwd_evt;
   logic [DW-1:0]    cap_a_d, cap_b_d;
   logic [CNT_W-1:0] fwd_cnt_d;

   // Write-back pass-through; blocked while reset is asserted
   assign wb_fire  = wb_valid & ~rst;
   assign wb_ready = ~rst;
   assign rf_we    = wb_fire;
   assign rf_wr    = wb_reg;
   assign rf_wd    = wb_data;

   // Request handshake and registered read addresses
   assign req_ready = (state_q == IDLE) & ~rst;
   assign rf_ra     = addr_a_q;
   assign rf_rb     = addr_b_q;

   assign op_valid  = op_valid_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign fwd_count = fwd_cnt_q;

   // Hardwired-zero ports never forward
   assign zero_a = ZERO_R0 && (addr_a_q == AW'(0));
   assign zero_b = ZERO_R0 && (addr_b_q == AW'(0));
   assign hit_a  = wb_fire && (wb_reg == addr_a_q) && !zero_a;
   assign hit_b  = wb_fire && (wb_reg == addr_b_q) && !zero_b;

   // A write in the accept cycle reaches the register file before it is
   // sampled, so only the ISSUE/CAPTURE/HOLD cycles forward.
   assign fwd_evt = (state_q != IDLE) && (hit_a || hit_b);

   // Capture priority: zero register, live write-back, ISSUE bypass, rf data
   always_comb begin
      cap_a_d = rf_rda;
      cap_b_d = rf_rdb;
      if (zero_a)           cap_a_d = '0;
      else if (hit_a)       cap_a_d = wb_data;
      else if (byp_a_vld_q) cap_a_d = byp_a_q;
      if (zero_b)           cap_b_d = '0;
      else if (hit_b)       cap_b_d = wb_data;
      else if (byp_b_vld_q) cap_b_d = byp_b_q;
   end

   // Saturating forwarding counter
   always_comb begin
      fwd_cnt_d = fwd_cnt_q;
      if (fwd_evt && !(&fwd_cnt_q)) fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
   end

   // Fetch FSM with registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_a_q    <= '0;
         addr_b_q    <= '0;
         byp_a_q     <= '0;
         byp_b_q     <= '0;
         byp_a_vld_q <= 1'b0;
         byp_b_vld_q <= 1'b0;
         op_valid_q  <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         fwd_cnt_q <= fwd_cnt_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_a_q    <= req_rs;
                  addr_b_q    <= req_rt;
                  byp_a_vld_q <= 1'b0;
                  byp_b_vld_q <= 1'b0;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               // Register file reads the old value at this edge; keep the new one
               if (hit_a) begin
                  byp_a_q     <= wb_data;
                  byp_a_vld_q <= 1'b1;
               end
               if (hit_b) begin
                  byp_b_q     <= wb_data;
                  byp_b_vld_q <= 1'b1;
               end
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               op_a_q     <= cap_a_d;
               op_b_q     <= cap_b_d;
               op_valid_q <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               // Held operands track write-backs, even on the release edge
               if (hit_a) op_a_q <= wb_data;
               if (hit_b) op_b_q <= wb_data;
               if (op_ready) begin
                  op_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
